mod12_down_counter: RTL

Synchronous modulo-N down counter, default MOD 12. It is the counting-direction counterpart of the team's mod-12 up counter. Counts from MOD-1 down to 0 and wraps, with count enable, synchronous parallel load, a range-checked load value, and a one-cycle terminal-count (borrow) pulse. Used as a countdown/timeout source and for checking wrap behaviour against the up counter.

---
 rtl/mod12_down_counter.sv | 53 +++++
 1 files changed

// File: rtl/mod12_down_counter.sv
// Modulo-MOD down counter (MOD-1 .. 0, wrapping) with enable, synchronous load,
// range-checked load value, one-cycle borrow pulse and a sticky bad-load flag.
module mod12_down_counter #(
    parameter int MOD   = 12,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             zero,
    output logic             err
);

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MOD - 1);

    // Compare one bit wider so MOD == 2**WIDTH still fits as a constant.
    logic loadLegal;
    assign loadLegal = ({1'b0, load_val} < (WIDTH + 1)'(MOD));

    // Priority is reset, then load, then count, then hold; tc only survives a counted wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out <= TOP_VAL;
            tc  <= 1'b0;
            err <= 1'b0;
        end else if (load) begin
            tc <= 1'b0;
            if (loadLegal) begin
                out <= load_val;
            end else begin
                out <= TOP_VAL;
                err <= 1'b1;
            end
        end else if (in) begin
            if (out == '0) begin
                out <= TOP_VAL;
                tc  <= 1'b1;
            end else begin
                out <= out - 1'b1;
                tc  <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

    assign zero = (out == '0);

endmodule
